// File: rtl/register_bank_nbit_if.sv
// Register bank access bundle: enables, function select, load data,
// read selects and the read/flag/wrap outputs. Drive via master.
interface register_bank_nbit_if #(
    parameter int WIDTH = 16,
    parameter int NREG  = 4
);
    localparam int SW = $clog2(NREG);

    logic [NREG-1:0]  E;
    logic [2:0]       FunSel;
    logic [WIDTH-1:0] I;
    logic [SW-1:0]    OutASel;
    logic [SW-1:0]    OutBSel;
    logic [WIDTH-1:0] OutA;
    logic [WIDTH-1:0] OutB;
    logic [NREG-1:0]  Zero;
    logic             Wrap;

    modport master (
        output E, FunSel, I, OutASel, OutBSel,
        input  OutA, OutB, Zero, Wrap
    );

    modport slave (
        input  E, FunSel, I, OutASel, OutBSel,
        output OutA, OutB, Zero, Wrap
    );
endinterface

// File: rtl/register_bank_nbit.sv
// NREG x WIDTH register bank: shared FunSel, per-register enable,
// two read ports, zero flags, registered inc/dec Wrap pulse.
// Ports: Clock, Reset (async, active low), bus (slave modport).
// REGBANK_SATURATE_EN: inc/dec saturate instead of wrapping.
module register_bank_nbit #(
    parameter int               WIDTH       = 16,
    parameter int               NREG        = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic                 Clock,
    input logic                 Reset,
    register_bank_nbit_if.slave bus
);
    localparam int SW = $clog2(NREG);
    localparam int H  = WIDTH / 2;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ONES = '1;
`ifdef REGBANK_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 2 || NREG < 2) begin : g_bad
            $error("register_bank_nbit: bad WIDTH/NREG");
        end
    endgenerate

    logic [WIDTH-1:0] q    [NREG];
    logic [WIDTH-1:0] q_nx [NREG];
    logic             wrap_q;
    logic             wrap_nx;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [NREG-1:0]  zero;

    // Wrap flags the attempt, so it also fires when saturating.
    always_comb begin
        wrap_nx = 1'b0;
        for (int k = 0; k < NREG; k++) begin
            q_nx[k] = q[k];
            if (bus.E[k]) begin
                unique case (bus.FunSel)
                    3'b000: begin
                        if (q[k] == '0) begin
                            wrap_nx = 1'b1;
                            q_nx[k] = SAT ? q[k] : q[k] - ONE;
                        end else begin
                            q_nx[k] = q[k] - ONE;
                        end
                    end
                    3'b001: begin
                        if (q[k] == ONES) begin
                            wrap_nx = 1'b1;
                            q_nx[k] = SAT ? q[k] : q[k] + ONE;
                        end else begin
                            q_nx[k] = q[k] + ONE;
                        end
                    end
                    3'b010: q_nx[k] = bus.I;
                    3'b011: q_nx[k] = '0;
                    3'b100: q_nx[k][H-1:0] = bus.I[H-1:0];
                    3'b101: q_nx[k][WIDTH-1:H] = bus.I[H-1:0];
                    3'b110: q_nx[k] = {q[k][WIDTH-2:0], 1'b0};
                    3'b111: q_nx[k] = {1'b0, q[k][WIDTH-1:1]};
                    default: q_nx[k] = q[k];
                endcase
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < NREG; k++) begin
                q[k] <= RESET_VALUE;
            end
            wrap_q <= 1'b0;
        end else begin
            for (int k = 0; k < NREG; k++) begin
                q[k] <= q_nx[k];
            end
            wrap_q <= wrap_nx;
        end
    end

    // Selects that match no register read as zero.
    always_comb begin
        out_a = '0;
        out_b = '0;
        for (int k = 0; k < NREG; k++) begin
            if (bus.OutASel == SW'(k)) out_a = q[k];
            if (bus.OutBSel == SW'(k)) out_b = q[k];
            zero[k] = (q[k] == '0);
        end
    end

    assign bus.OutA = out_a;
    assign bus.OutB = out_b;
    assign bus.Zero = zero;
    assign bus.Wrap = wrap_q;
endmodule

// File: tb/tb_register_bank_nbit.sv
// Directed vector bench for register_bank_nbit (NREG=4 and NREG=3).
// Ports exercised through the bank interface.
module tb_register_bank_nbit;
`ifdef REGBANK_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [3:0]  e;
        logic [2:0]  fs;
        logic [15:0] i;
        logic [1:0]  sel;
        logic [15:0] exp;
        logic        wrap;
    } vec_t;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   total = 0;
    int   pass  = 0;

    always #5 Clock = ~Clock;

    register_bank_nbit_if #(.WIDTH(16), .NREG(4)) bus4 ();
    register_bank_nbit_if #(.WIDTH(16), .NREG(3)) bus3 ();

    register_bank_nbit #(.WIDTH(16), .NREG(4)) u4 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus4)
    );

    register_bank_nbit #(.WIDTH(16), .NREG(3)) u3 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus3)
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic vec_t mk(logic [3:0] e, logic [2:0] fs,
                                logic [15:0] i, logic [1:0] sel,
                                logic [15:0] exp, logic wrap);
        vec_t v;
        v.e = e; v.fs = fs; v.i = i;
        v.sel = sel; v.exp = exp; v.wrap = wrap;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        // Table, starting from all-zero registers.
        vecs.push_back(mk(4'b0100, 3'b010, 16'hBEEF, 2, 16'hBEEF, 0));
        vecs.push_back(mk(4'b0000, 3'b011, 16'h0000, 2, 16'hBEEF, 0));
        vecs.push_back(mk(4'b0100, 3'b100, 16'h0012, 2, 16'hBE12, 0));
        vecs.push_back(mk(4'b0100, 3'b101, 16'h0034, 2, 16'h3412, 0));
        vecs.push_back(mk(4'b0000, 3'b000, 16'h0000, 0, 16'h0000, 0));
        vecs.push_back(mk(4'b0000, 3'b000, 16'h0000, 1, 16'h0000, 0));
        vecs.push_back(mk(4'b0000, 3'b000, 16'h0000, 3, 16'h0000, 0));
        vecs.push_back(mk(4'b0010, 3'b010, 16'hFFFF, 1, 16'hFFFF, 0));
        vecs.push_back(mk(4'b0010, 3'b001, 16'h0000, 1,
                          SAT ? 16'hFFFF : 16'h0000, 1));
        vecs.push_back(mk(4'b0000, 3'b001, 16'h0000, 1,
                          SAT ? 16'hFFFF : 16'h0000, 0));
        vecs.push_back(mk(4'b0010, 3'b000, 16'h0000, 1,
                          SAT ? 16'hFFFE : 16'hFFFF, !SAT));
        vecs.push_back(mk(4'b0010, 3'b011, 16'h0000, 1, 16'h0000, 0));
        vecs.push_back(mk(4'b0010, 3'b000, 16'h0000, 1,
                          SAT ? 16'h0000 : 16'hFFFF, 1));
        vecs.push_back(mk(4'b0010, 3'b000, 16'h0000, 1,
                          SAT ? 16'h0000 : 16'hFFFE, SAT));
        vecs.push_back(mk(4'b0010, 3'b001, 16'h0000, 1,
                          SAT ? 16'h0001 : 16'hFFFF, 0));
        vecs.push_back(mk(4'b0010, 3'b001, 16'h0000, 1,
                          SAT ? 16'h0002 : 16'h0000, !SAT));
        vecs.push_back(mk(4'b0010, 3'b000, 16'h0000, 1,
                          SAT ? 16'h0001 : 16'hFFFF, !SAT));
        vecs.push_back(mk(4'b1000, 3'b010, 16'h8001, 3, 16'h8001, 0));
        vecs.push_back(mk(4'b1000, 3'b110, 16'h0000, 3, 16'h0002, 0));
        vecs.push_back(mk(4'b1000, 3'b010, 16'h8001, 3, 16'h8001, 0));
        vecs.push_back(mk(4'b1000, 3'b111, 16'h0000, 3, 16'h4000, 0));
        vecs.push_back(mk(4'b1000, 3'b111, 16'h0000, 3, 16'h2000, 0));
        vecs.push_back(mk(4'b0000, 3'b110, 16'h0000, 2, 16'h3412, 0));
        vecs.push_back(mk(4'b1111, 3'b110, 16'h0000, 2, 16'h6824, 0));

        bus4.E = '0; bus4.FunSel = '0; bus4.I = '0;
        bus4.OutASel = '0; bus4.OutBSel = '0;
        bus3.E = '0; bus3.FunSel = '0; bus3.I = '0;
        bus3.OutASel = '0; bus3.OutBSel = '0;

        // Reset mid-cycle while incrementing.
        step();
        Reset = 1'b1;
        bus4.E = 4'b1111;
        bus4.FunSel = 3'b001;
        step();
        step();
        #3;
        Reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            bus4.OutASel = 2'(k);
            bus4.OutBSel = 2'(3 - k);
            #1;
            chk("rst_outa", 32'(bus4.OutA), 32'h0);
            chk("rst_outb", 32'(bus4.OutB), 32'h0);
        end
        chk("rst_zero", 32'(bus4.Zero), 32'hF);
        chk("rst_wrap", 32'(bus4.Wrap), 32'h0);
        step();
        chk("rst_hold", 32'(bus4.Zero), 32'hF);
        Reset = 1'b1;
        step();
        bus4.E = '0;
        for (int k = 0; k < 4; k++) begin
            bus4.OutASel = 2'(k);
            #1;
            chk("post_rst_inc", 32'(bus4.OutA), 32'h0001);
        end

        // Clean start for the table.
        Reset = 1'b0;
        #2;
        Reset = 1'b1;
        foreach (vecs[n]) begin
            bus4.E = vecs[n].e;
            bus4.FunSel = vecs[n].fs;
            bus4.I = vecs[n].i;
            bus4.OutASel = vecs[n].sel;
            bus4.OutBSel = vecs[n].sel;
            step();
            chk($sformatf("v%0d_outa", n), 32'(bus4.OutA),
                32'(vecs[n].exp));
            chk($sformatf("v%0d_outb", n), 32'(bus4.OutB),
                32'(vecs[n].exp));
            chk($sformatf("v%0d_wrap", n), 32'(bus4.Wrap),
                32'(vecs[n].wrap));
            chk($sformatf("v%0d_zero", n),
                32'(bus4.Zero[vecs[n].sel]),
                32'(vecs[n].exp == 16'h0));
        end
        bus4.E = '0;

        // NREG=3: multi-enable clear then increment.
        bus3.E = 3'b111;
        bus3.FunSel = 3'b011;
        step();
        chk("n3_clear_zero", 32'(bus3.Zero), 32'h7);
        bus3.FunSel = 3'b001;
        step();
        bus3.E = '0;
        chk("n3_inc_zero", 32'(bus3.Zero), 32'h0);
        chk("n3_inc_wrap", 32'(bus3.Wrap), 32'h0);
        for (int k = 0; k < 3; k++) begin
            bus3.OutASel = 2'(k);
            #1;
            chk("n3_read", 32'(bus3.OutA), 32'h0001);
        end
        bus3.OutASel = 2'd2;
        bus3.OutBSel = 2'd2;
        #1;
        chk("n3_same_a", 32'(bus3.OutA), 32'h0001);
        chk("n3_same_b", 32'(bus3.OutB), 32'h0001);
        bus3.OutASel = 2'd3;
        #1;
        chk("n3_oob_a", 32'(bus3.OutA), 32'h0000);
        chk("n3_oob_b", 32'(bus3.OutB), 32'h0001);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/register_bank_nbit.md
Name: register_bank_nbit

Overview:
- Parametrised bank of NREG general-purpose registers, each WIDTH bits wide.
- One 3-bit function select is shared by all registers; each register has its own enable bit.
- Functions: increment, decrement, load, clear, half-word loads and 1-bit shifts.
- Two independent read ports and per-register zero flags feed the ALU/address path; a registered wrap pulse reports counter overflow/underflow to the control unit.

Parameters:
- WIDTH, 16, register width in bits; must be even and >= 2.
- NREG, 4, number of registers; must be >= 2.
- RESET_VALUE, 0, value every register takes on reset, WIDTH bits.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- E  input  NREG  per-register enable; bit k enables register k.
- FunSel  input  3  operation applied to every enabled register.
- I  input  WIDTH  load data.
- OutASel  input  SW  read port A select, where SW = $clog2(NREG).
- OutBSel  input  SW  read port B select.
- OutA  output  WIDTH  contents of register OutASel.
- OutB  output  WIDTH  contents of register OutBSel.
- Zero  output  NREG  bit k = 1 when register k is all zeros.
- Wrap  output  1  registered event pulse for inc/dec overflow or underflow.

Behaviour:
- Reset low, asynchronous:
  - all registers = RESET_VALUE; Wrap = 0.
  - Takes effect immediately, regardless of Clock, E or FunSel; aborts any operation in flight.
  - While Reset is low, registers hold RESET_VALUE and clock edges are ignored.
- On each rising Clock edge with Reset high, every register k with E[k]=1 updates; E[k]=0 holds its value. H = WIDTH/2.
  - 000: Q <= Q - 1, modulo 2^WIDTH.
  - 001: Q <= Q + 1, modulo 2^WIDTH.
  - 010: Q <= I.
  - 011: Q <= 0.
  - 100: Q[H-1:0] <= I[H-1:0]; upper half held.
  - 101: Q[WIDTH-1:H] <= I[H-1:0]; lower half held (low half of I goes to the high half of Q).
  - 110: Q <= Q << 1; LSB filled with 0.
  - 111: Q <= Q >> 1, logical; MSB filled with 0.
- Multiple enable bits set at once: all selected registers perform the same operation in the same cycle, each on its own old value.
- Read ports:
  - Combinational from current register state; a write becomes visible on OutA/OutB in the cycle after the edge. No write-through.
  - OutASel == OutBSel is legal; both ports show the same value.
  - Select >= NREG (NREG not a power of 2): port outputs 0.
- Zero: combinational from current register state, one bit per register.
- Wrap:
  - Registered; 1 for exactly the cycle after an edge where at least one enabled register did increment from all-ones or decrement from 0.
  - Otherwise 0. Back-to-back wraps give Wrap high on consecutive cycles.
  - Shifts and loads never set Wrap.
- Elaboration: WIDTH odd, WIDTH < 2 or NREG < 2 stops elaboration via a generate-time error.

Optional Feature:
- Macro: REGBANK_SATURATE_EN.
- Defined:
  - Increment at all-ones holds all-ones; decrement at 0 holds 0.
  - Wrap still pulses on such an attempt, so the control unit sees the saturation event.
- Undefined: modular wrap-around as described in Behaviour.
- All other functions are identical in both builds.

Test Plan (WIDTH=16, NREG=4 unless noted):
- Reset values: Reset low mid-cycle while E=4'b1111, FunSel=001 -> all OutA/OutB reads 0x0000 immediately, Zero=4'b1111, Wrap=0; after Reset releases, one edge gives all registers 0x0001.
- Per-register enable: E=4'b0100, FunSel=010, I=0xBEEF -> R2=0xBEEF; R0, R1, R3 unchanged. Then FunSel=100, I=0x0012 -> R2=0xBE12. Then FunSel=101, I=0x0034 -> R2=0x3412.
- Wrap, no macro: R1=0xFFFF, E=4'b0010, FunSel=001 -> R1=0x0000, Zero[1]=1, Wrap=1 for one cycle. Then FunSel=000 -> R1=0xFFFF, Wrap=1 again.
- Wrap, REGBANK_SATURATE_EN defined: same stimulus -> R1 stays 0xFFFF with Wrap=1. From R1=0x0000 with FunSel=000 -> stays 0x0000 with Wrap=1.
- Shifts: R3=0x8001, FunSel=110 -> 0x0002. FunSel=111 twice from 0x8001 -> 0x4000, then 0x2000. Wrap=0 throughout.
- Multi-enable and ports, NREG=3: E=3'b111, FunSel=011, then FunSel=001 -> R0=R1=R2=0x0001. OutASel=OutBSel=2 -> both read 0x0001. OutASel=3 -> OutA reads 0x0000.
